// File: rtl/adc_dac_loop_mc_pkg.sv
// rtl/adc_dac_loop_mc_pkg.sv - shared FSM states, fixed-point constant and width reduction helper
// Build option: define ADC_DAC_LOOP_MC_SAT_EN to clamp results instead of wrapping.
package adc_dac_loop_mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACQ,
        ST_CAL_ADC,
        ST_CAL_DAC,
        ST_FIN
    } state_t;

    localparam int          FRAC_BITS_DEF = 16;
    localparam logic [31:0] FP_ONE        = 32'h0000_0001 << FRAC_BITS_DEF;

    // Wide enough to hold a full FP product shifted back plus an offset.
    localparam int RED_W = 160;

`ifdef ADC_DAC_LOOP_MC_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    // Reduce a wide signed value to w bits: clamp when saturation is built in,
    // otherwise keep the low bits (two's-complement wrap).
    function automatic logic [RED_W-1:0] reduce_word(
        input logic signed [RED_W-1:0] v,
        input int                      w,
        input logic                    unsigned_rng
    );
        logic signed [RED_W-1:0] one;
        logic signed [RED_W-1:0] hi;
        logic signed [RED_W-1:0] lo;
        logic signed [RED_W-1:0] r;
        one = {{(RED_W-1){1'b0}}, 1'b1};
        if (unsigned_rng) begin
            hi = (one << w) - one;
            lo = '0;
        end else begin
            hi = (one << (w - 1)) - one;
            lo = -(one << (w - 1));
        end
        r = v;
        if (SAT_ON) begin
            if (v > hi)
                r = hi;
            else if (v < lo)
                r = lo;
        end
        return r & ((one << w) - one);
    endfunction

endpackage

// File: rtl/adc_dac_loop_mc_if.sv
// rtl/adc_dac_loop_mc_if.sv - run control, sample, config and result bundle
interface adc_dac_loop_mc_if #(
    parameter int NUM_CH    = 2,
    parameter int ADC_WIDTH = 12,
    parameter int DAC_WIDTH = 14,
    parameter int FP_WIDTH  = 32
);
    logic                            enable;
    logic [NUM_CH*ADC_WIDTH-1:0]     adc_data;
    logic [NUM_CH*4*FP_WIDTH-1:0]    cfg;
    logic [NUM_CH*FP_WIDTH-1:0]      volt;
    logic [NUM_CH*DAC_WIDTH-1:0]     dac_code;
    logic                            busy;
    logic                            done;

    modport master (
        output enable, adc_data, cfg,
        input  volt, dac_code, busy, done
    );

    modport slave (
        input  enable, adc_data, cfg,
        output volt, dac_code, busy, done
    );
endinterface

// File: rtl/adc_dac_loop_mc_cal_mac.sv
// rtl/adc_dac_loop_mc_cal_mac.sv - shared combinational (a*b)>>>FRAC_BITS +/- c with width reduction
module cal_mac
    import adc_dac_loop_mc_pkg::*;
#(
    parameter int FP_WIDTH  = 32,
    parameter int FRAC_BITS = 16,
    parameter int DAC_WIDTH = 14
) (
    input  logic signed [FP_WIDTH-1:0] a,
    input  logic signed [FP_WIDTH-1:0] b,
    input  logic signed [FP_WIDTH-1:0] c,
    input  logic                       add_c,
    output logic        [FP_WIDTH-1:0] volt,
    output logic        [DAC_WIDTH-1:0] code
);
    localparam int PW = 2 * FP_WIDTH;

    logic signed [PW-1:0]    prod;
    logic signed [RED_W-1:0] scaled;
    logic signed [RED_W-1:0] sum;

    assign prod   = PW'(a) * PW'(b);
    assign scaled = RED_W'(prod) >>> FRAC_BITS;
    // ADC calibration subtracts its offset, DAC calibration adds it.
    assign sum    = add_c ? scaled + RED_W'(c) : scaled - RED_W'(c);

    assign volt = FP_WIDTH'(reduce_word(sum, FP_WIDTH, 1'b0));
    assign code = DAC_WIDTH'(reduce_word(sum >>> FRAC_BITS, DAC_WIDTH, 1'b1));

endmodule

// File: rtl/adc_dac_loop_mc.sv
// rtl/adc_dac_loop_mc.sv - multichannel ADC averaging, calibration and DAC code loop
// Build option: ADC_DAC_LOOP_MC_SAT_EN selects clamping in the shared calibration datapath.
module adc_dac_loop_mc
    import adc_dac_loop_mc_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADC_WIDTH  = 12,
    parameter int DAC_WIDTH  = 14,
    parameter int FP_WIDTH   = 32,
    parameter int FRAC_BITS  = 16,
    parameter int LOG2_SAMPS = 10
) (
    input  logic             adc_clk,
    input  logic             rst,
    adc_dac_loop_mc_if.slave bus
);
    localparam int ACC_W = ADC_WIDTH + LOG2_SAMPS;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [LOG2_SAMPS:0] SAMP_LAST = (LOG2_SAMPS+1)'(1 << LOG2_SAMPS);
    localparam logic [CH_W-1:0]     LAST_CH   = CH_W'(NUM_CH - 1);

    state_t                       state;
    state_t                       state_nx;
    logic [LOG2_SAMPS:0]          cnt;
    logic [CH_W-1:0]              ch_idx;
    logic [ACC_W-1:0]             acc    [NUM_CH];
    logic [FP_WIDTH-1:0]          volt_r [NUM_CH];
    logic [DAC_WIDTH-1:0]         code_r [NUM_CH];
    logic [NUM_CH*4*FP_WIDTH-1:0] cfg_sh;

    logic                         last_samp;
    logic                         last_ch;
    logic signed [FP_WIDTH-1:0]   mac_a;
    logic signed [FP_WIDTH-1:0]   mac_b;
    logic signed [FP_WIDTH-1:0]   mac_c;
    logic                         mac_add;
    logic [FP_WIDTH-1:0]          mac_volt;
    logic [DAC_WIDTH-1:0]         mac_code;
    logic [ACC_W-1:0]             acc_sel;
    int                           base;

    assign last_samp = (cnt == SAMP_LAST);
    assign last_ch   = (ch_idx == LAST_CH);

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (bus.enable) state_nx = ST_ACQ;
            ST_ACQ: begin
                if (!bus.enable)
                    state_nx = ST_IDLE;
                else if (last_samp)
                    state_nx = ST_CAL_ADC;
            end
            ST_CAL_ADC: if (last_ch) state_nx = ST_CAL_DAC;
            ST_CAL_DAC: if (last_ch) state_nx = ST_FIN;
            ST_FIN:     state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // One multiplier serves both calibration phases; the channel index picks operands.
    always_comb begin
        base    = 4 * int'(ch_idx) * FP_WIDTH;
        acc_sel = acc[ch_idx];
        mac_a   = FP_WIDTH'(acc_sel >> LOG2_SAMPS) << FRAC_BITS;
        mac_b   = cfg_sh[base +: FP_WIDTH];
        mac_c   = cfg_sh[base + FP_WIDTH +: FP_WIDTH];
        mac_add = 1'b0;
        if (state == ST_CAL_DAC) begin
            mac_a   = volt_r[ch_idx];
            mac_b   = cfg_sh[base + 2*FP_WIDTH +: FP_WIDTH];
            mac_c   = cfg_sh[base + 3*FP_WIDTH +: FP_WIDTH];
            mac_add = 1'b1;
        end
    end

    cal_mac #(
        .FP_WIDTH  (FP_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .DAC_WIDTH (DAC_WIDTH)
    ) u_cal_mac (
        .a     (mac_a),
        .b     (mac_b),
        .c     (mac_c),
        .add_c (mac_add),
        .volt  (mac_volt),
        .code  (mac_code)
    );

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            ch_idx <= '0;
            cfg_sh <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc[k]    <= '0;
                volt_r[k] <= '0;
                code_r[k] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        cfg_sh <= bus.cfg;
                        cnt    <= '0;
                        ch_idx <= '0;
                        for (int k = 0; k < NUM_CH; k++)
                            acc[k] <= '0;
                    end
                end
                ST_ACQ: begin
                    if (!bus.enable) begin
                        cnt <= '0;
                        for (int k = 0; k < NUM_CH; k++)
                            acc[k] <= '0;
                    end else begin
                        cnt <= cnt + (LOG2_SAMPS+1)'(1);
                        // First ACQ cycle is a settle cycle; samples follow.
                        if (cnt != '0) begin
                            for (int k = 0; k < NUM_CH; k++)
                                acc[k] <= acc[k] + ACC_W'(bus.adc_data[k*ADC_WIDTH +: ADC_WIDTH]);
                        end
                    end
                end
                ST_CAL_ADC: begin
                    volt_r[ch_idx] <= mac_volt;
                    ch_idx         <= last_ch ? '0 : ch_idx + CH_W'(1);
                end
                ST_CAL_DAC: begin
                    code_r[ch_idx] <= mac_code;
                    ch_idx         <= last_ch ? '0 : ch_idx + CH_W'(1);
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign bus.volt[g*FP_WIDTH +: FP_WIDTH]       = volt_r[g];
        assign bus.dac_code[g*DAC_WIDTH +: DAC_WIDTH] = code_r[g];
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = (state == ST_FIN);

endmodule

// File: tb/tb_adc_dac_loop_mc.sv
// tb/tb_adc_dac_loop_mc.sv - directed checks of averaging, calibration, abort, free-run and reset
module tb_adc_dac_loop_mc;

    logic clk = 1'b0;
    logic rst;
    int   cyc;
    int   n_total = 0;
    int   n_pass  = 0;
    int   seen;

    adc_dac_loop_mc_if #(
        .NUM_CH(2), .ADC_WIDTH(12), .DAC_WIDTH(14), .FP_WIDTH(32)
    ) bus ();

    adc_dac_loop_mc #(
        .NUM_CH(2), .ADC_WIDTH(12), .DAC_WIDTH(14),
        .FP_WIDTH(32), .FRAC_BITS(16), .LOG2_SAMPS(2)
    ) dut (
        .adc_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

`ifdef ADC_DAC_LOOP_MC_SAT_EN
    localparam logic [63:0] EXP_BIG_CODE = 64'd16383;
    localparam logic [63:0] EXP_NEG_CODE = 64'd0;
`else
    localparam logic [63:0] EXP_BIG_CODE = 64'd9216;
    localparam logic [63:0] EXP_NEG_CODE = 64'd16284;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_cfg(input int k, input logic [31:0] ag, input logic [31:0] ao,
                           input logic [31:0] dg, input logic [31:0] dof);
        bus.cfg[(4*k+0)*32 +: 32] = ag;
        bus.cfg[(4*k+1)*32 +: 32] = ao;
        bus.cfg[(4*k+2)*32 +: 32] = dg;
        bus.cfg[(4*k+3)*32 +: 32] = dof;
    endtask

    task automatic set_adc(input logic [11:0] s0, input logic [11:0] s1);
        bus.adc_data = {s1, s0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_start();
        @(negedge clk);
        bus.enable = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_done(input int limit, input bit drop);
        int start;
        start = cyc;
        do step(); while (!bus.done && (cyc - start) < limit);
        if (drop)
            bus.enable = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [31:0] v0, input logic [31:0] v1,
                              input logic [63:0] c0, input logic [63:0] c1);
        check({tag, "_volt0"}, 64'(bus.volt[31:0]),      64'(v0));
        check({tag, "_volt1"}, 64'(bus.volt[63:32]),     64'(v1));
        check({tag, "_code0"}, 64'(bus.dac_code[13:0]),  c0);
        check({tag, "_code1"}, 64'(bus.dac_code[27:14]), c1);
    endtask

    initial begin
        rst          = 1'b1;
        bus.enable   = 1'b0;
        bus.adc_data = '0;
        bus.cfg      = '0;
        cyc          = 0;
        #1;
        check_outs("reset", 32'h0, 32'h0, 64'd0, 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Unity gains, zero offsets, constant samples.
        set_cfg(0, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0);
        set_cfg(1, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0);
        set_adc(12'd100, 12'd2000);
        run_start();
        wait_done(40, 1'b1);
        check("unity_latency", 64'(cyc), 64'd10);
        check_outs("unity", 32'h0064_0000, 32'h07D0_0000, 64'd100, 64'd2000);
        step();
        check("unity_idle_busy", 64'(bus.busy), 64'd0);

        // Varying ch0 samples (sum 101 -> avg 25), ch1 full scale at half gain.
        set_cfg(1, 32'h0000_8000, 32'h0, 32'h0001_0000, 32'h0);
        set_adc(12'd0, 12'd4095);
        run_start();
        step();
        step();
        set_adc(12'd10, 12'd4095);
        step();
        set_adc(12'd20, 12'd4095);
        step();
        set_adc(12'd30, 12'd4095);
        step();
        set_adc(12'd41, 12'd4095);
        wait_done(40, 1'b1);
        check("avg_latency", 64'(cyc), 64'd10);
        check_outs("avg", 32'h0019_0000, 32'h07FF_8000, 64'd25, 64'd2047);

        // Large DAC gain on ch0; config changed mid-run must not take effect.
        set_cfg(0, 32'h0001_0000, 32'h0, 32'h0100_0000, 32'h0);
        set_cfg(1, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0);
        set_adc(12'd100, 12'd2000);
        run_start();
        step();
        step();
        set_cfg(0, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0);
        wait_done(40, 1'b1);
        check_outs("dacgain", 32'h0064_0000, 32'h07D0_0000, EXP_BIG_CODE, 64'd2000);

        // ADC offset drives ch0 voltage negative.
        set_cfg(0, 32'h0001_0000, 32'h00C8_0000, 32'h0001_0000, 32'h0);
        run_start();
        wait_done(40, 1'b1);
        check_outs("adcoff", 32'hFF9C_0000, 32'h07D0_0000, EXP_NEG_CODE, 64'd2000);

        // Abort in ACQ cycle 2: no DONE, outputs keep previous run.
        set_cfg(0, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0);
        set_adc(12'd500, 12'd500);
        run_start();
        step();
        step();
        bus.enable = 1'b0;
        step();
        check("abort_busy", 64'(bus.busy), 64'd0);
        seen = 0;
        repeat (12) begin
            step();
            if (bus.done) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check_outs("abort", 32'hFF9C_0000, 32'h07D0_0000, EXP_NEG_CODE, 64'd2000);

        // Free-running with ENABLE held high, then asynchronous reset mid CAL_DAC.
        set_adc(12'd300, 12'd40);
        run_start();
        wait_done(40, 1'b0);
        check("free_done1", 64'(cyc), 64'd10);
        wait_done(40, 1'b0);
        check("free_done2", 64'(cyc), 64'd21);
        repeat (9) step();
        check("free_volt0_pre", 64'(bus.volt[31:0]), 64'h0000_0000_012C_0000);
        check("free_busy_pre", 64'(bus.busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 32'h0, 32'h0, 64'd0, 64'd0);
        check("async_rst_busy", 64'(bus.busy), 64'd0);
        check("async_rst_done", 64'(bus.done), 64'd0);
        bus.enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_busy", 64'(bus.busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adc_dac_loop_mc.md
ADC_DAC_LOOP_MC -- requirements
Module: adc_dac_loop_mc

Interface
REQ-001 Parameter NUM_CH, default 2: number of parallel ADC/DAC channels (1..8).
REQ-002 Parameter ADC_WIDTH, default 12: unsigned ADC sample width.
REQ-003 Parameter DAC_WIDTH, default 14: unsigned DAC code width.
REQ-004 Parameter FP_WIDTH, default 32: signed fixed-point word width.
REQ-005 Parameter FRAC_BITS, default 16: fractional bits of every fixed-point word.
REQ-006 Parameter LOG2_SAMPS, default 10: log2 of samples averaged per run.
REQ-007 ADC_CLK  in  1: sole clock; all logic on rising edge.
REQ-008 RST  in  1: reset, asynchronous, active-high.
REQ-009 ENABLE  in  1: run request, level-sensitive.
REQ-010 ADC_DATA_IN  in  NUM_CH*ADC_WIDTH: packed samples, channel k at bits [k*ADC_WIDTH +: ADC_WIDTH].
REQ-011 CFG_IN  in  NUM_CH*4*FP_WIDTH: per channel k, words 4k..4k+3 = ADC gain, ADC offset, DAC gain, DAC offset.
REQ-012 VOLT_OUT  out  NUM_CH*FP_WIDTH: calibrated voltage per channel.
REQ-013 DAC_CODE_OUT  out  NUM_CH*DAC_WIDTH: DAC code per channel.
REQ-014 BUSY  out  1: high in any state other than IDLE.
REQ-015 DONE  out  1: one-cycle pulse when all outputs of a run are updated.

Function
REQ-016 FSM states IDLE, ACQ, CAL_ADC, CAL_DAC, FIN; IDLE->ACQ when ENABLE=1.
REQ-017 On ACQ entry, CFG_IN is captured into a shadow register; changes to CFG_IN during a run have no effect until next run.
REQ-018 ACQ: each cycle, every channel accumulator adds its sample; accumulator width ADC_WIDTH+LOG2_SAMPS, no overflow possible; exactly 2^LOG2_SAMPS samples, first sample on the cycle after ACQ entry.
REQ-019 After last sample, avg_k = acc_k >> LOG2_SAMPS, zero-extended then shifted left FRAC_BITS to a fixed-point word.
REQ-020 CAL_ADC (one cycle per channel, k ascending): volt_k = ((avg_k * adc_gain_k) >>> FRAC_BITS) - adc_offset_k, signed, width-reduced per REQ-029, registered into VOLT_OUT slot k.
REQ-021 CAL_DAC (one cycle per channel, k ascending): d = ((volt_k * dac_gain_k) >>> FRAC_BITS) + dac_offset_k; code_k = d >>> FRAC_BITS reduced to DAC_WIDTH per REQ-029, registered into DAC_CODE_OUT slot k.
REQ-022 FIN: DONE=1 for exactly one cycle, then IDLE; if ENABLE still high, next run starts on the following cycle (free-running).
REQ-023 Latency: ENABLE sampled high in IDLE at cycle 0 -> DONE high at cycle 2^LOG2_SAMPS + 2*NUM_CH + 2.
REQ-024 ENABLE low during ACQ aborts to IDLE next cycle; accumulators cleared; VOLT_OUT/DAC_CODE_OUT unchanged; no DONE.
REQ-025 ENABLE low during CAL_ADC/CAL_DAC/FIN is ignored; run completes.
REQ-026 VOLT_OUT and DAC_CODE_OUT hold their values between runs.
REQ-027 Only one multiplier pair instance (shared across channels via channel index counter).

Reset
REQ-028 RST=1 forces IDLE, accumulators 0, shadow config 0, VOLT_OUT 0, DAC_CODE_OUT 0, BUSY 0, DONE 0, immediately and independent of ADC_CLK; reset mid-run discards the run.

Configuration
REQ-029 Macro ADC_DAC_LOOP_MC_SAT_EN defined: VOLT_OUT clamps to signed FP_WIDTH min/max and DAC code clamps to [0, 2^DAC_WIDTH-1]; undefined: both truncate to low bits (two's-complement wrap).

Structure
REQ-030 Package adc_dac_loop_mc_pkg holds FSM state enum, fixed-point one constant (1<<FRAC_BITS) and the saturate/truncate function.
REQ-031 Sub-module cal_mac: combinational (a*b)>>>FRAC_BITS + c with width reduction; instantiated once.

Verification (NUM_CH=2, LOG2_SAMPS=2, FP_WIDTH=32, FRAC_BITS=16, ADC 12b, DAC 14b)
REQ-032 Gains 0x0001_0000, offsets 0, ADC ch0=100 ch1=2000 constant, ENABLE pulse -> VOLT_OUT 0x0064_0000/0x07D0_0000, codes 100/2000, DONE at cycle 10.
REQ-033 ch0 DAC gain 0x0100_0000, ADC 100 -> code 16383 with SAT_EN, 9216 without.
REQ-034 ch0 ADC offset 0x00C8_0000, ADC 100 -> VOLT_OUT 0xFF9C_0000, code 0 with SAT_EN.
REQ-035 ENABLE dropped at ACQ cycle 2 -> no DONE, outputs keep prior run values, BUSY low next cycle.
REQ-036 ENABLE held high -> DONE every 11 cycles; RST asserted mid-CAL_DAC -> all outputs 0 asynchronously, IDLE.
